// File: rtl/load_store_unit_if.sv
//------------------------------------------------------------------------------
// Module      : load_store_unit_if
// Description : Single-beat memory request/ack bus between LSU and memory.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
//------------------------------------------------------------------------------
// Module      : load_store_unit
// Description : Byte/half/word load-store unit; unaligned accesses split into
//               two word beats with lane steering and load extension.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_store_unit (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        clk_enable,
    input  wire logic        start,
    input  wire logic        is_store,
    input  wire logic [1:0]  size,
    input  wire logic        load_unsigned,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] addr_next,
    input  wire logic [31:0] store_data,
    output logic      [31:0] load_data,
    output logic             done,
    output logic             busy,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_is_store;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_addr_next;
    logic [31:0] r_store_data;
    logic [31:0] r_rbuf_lo;
    logic [31:0] r_load_data;

    logic [1:0]  w_off;
    logic [2:0]  w_nbytes;
    logic        w_split;
    logic [7:0]  w_byte_mask;
    logic [7:0]  w_strb64;
    logic [31:0] w_data_masked;
    logic [63:0] w_wdata64;
    logic [55:0] w_window;
    logic [31:0] w_aligned;
    logic [31:0] w_load_result;

    logic        w_req;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic        w_done;

    assign w_off = r_addr[1:0];

    always_comb begin
        w_nbytes      = 3'd4;
        w_byte_mask   = 8'h0F;
        w_data_masked = r_store_data;
        case (r_size)
            2'b00: begin
                w_nbytes      = 3'd1;
                w_byte_mask   = 8'h01;
                w_data_masked = {24'h0, r_store_data[7:0]};
            end
            2'b01: begin
                w_nbytes      = 3'd2;
                w_byte_mask   = 8'h03;
                w_data_masked = {16'h0, r_store_data[15:0]};
            end
            default: ;
        endcase
    end

    assign w_split   = (({1'b0, w_off} + w_nbytes) > 3'd4);
    assign w_strb64  = w_byte_mask << w_off;
    assign w_wdata64 = {32'h0, w_data_masked} << {w_off, 3'b000};

    // Only 56 bits of the two-beat buffer can ever reach the result window,
    // and the live high half is taken straight from the bus in the ack cycle.
    assign w_window = (r_state == BEAT1) ? {mem.mem_rdata[23:0], r_rbuf_lo}
                                         : {24'h0, mem.mem_rdata};

    always_comb begin
        w_aligned = w_window[31:0];
        case (w_off)
            2'd1:    w_aligned = w_window[39:8];
            2'd2:    w_aligned = w_window[47:16];
            2'd3:    w_aligned = w_window[55:24];
            default: w_aligned = w_window[31:0];
        endcase
    end

    always_comb begin
        w_load_result = w_aligned;
        case (r_size)
            2'b00: w_load_result = {{24{~r_unsigned & w_aligned[7]}},  w_aligned[7:0]};
            2'b01: w_load_result = {{16{~r_unsigned & w_aligned[15]}}, w_aligned[15:0]};
            default: w_load_result = w_aligned;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = 32'h0;
        w_wdata      = 32'h0;
        w_wstrb      = 4'h0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_next = BEAT0;
            end
            BEAT0: begin
                w_req  = 1'b1;
                w_we   = r_is_store;
                w_addr = {r_addr[31:2], 2'b00};
                if (r_is_store) begin
                    w_wdata = w_wdata64[31:0];
                    w_wstrb = w_strb64[3:0];
                end
                if (mem.mem_ack) w_state_next = w_split ? BEAT1 : DONE;
            end
            BEAT1: begin
                w_req  = 1'b1;
                w_we   = r_is_store;
                w_addr = r_addr_next & 32'hFFFF_FFFC;
                if (r_is_store) begin
                    w_wdata = w_wdata64[63:32];
                    w_wstrb = w_strb64[7:4];
                end
                if (mem.mem_ack) w_state_next = DONE;
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (clk_enable) begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= 32'h0;
            r_addr_next  <= 32'h0;
            r_store_data <= 32'h0;
        end else if (clk_enable && (r_state == IDLE) && start) begin
            r_is_store   <= is_store;
            r_size       <= size;
            r_unsigned   <= load_unsigned;
            r_addr       <= addr;
            r_addr_next  <= addr_next;
            r_store_data <= store_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rbuf_lo   <= 32'h0;
            r_load_data <= 32'h0;
        end else if (clk_enable) begin
            if ((r_state == BEAT0) && mem.mem_ack) r_rbuf_lo <= mem.mem_rdata;
            if ((r_state != DONE) && (w_state_next == DONE) && !r_is_store)
                r_load_data <= w_load_result;
        end
    end

    assign mem.mem_req   = w_req;
    assign mem.mem_we    = w_we;
    assign mem.mem_addr  = w_addr;
    assign mem.mem_wdata = w_wdata;
    assign mem.mem_wstrb = w_wstrb;
    assign load_data     = r_load_data;
    assign done          = w_done;
    assign busy          = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_enable;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] addr_next;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    load_store_unit_if mif();

    load_store_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_enable    (clk_enable),
        .start         (start),
        .is_store      (is_store),
        .size          (size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .addr_next     (addr_next),
        .store_data    (store_data),
        .load_data     (load_data),
        .done          (done),
        .busy          (busy),
        .mem           (mif.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] an, input logic [31:0] sd);
        is_store      = st;
        size          = sz;
        load_unsigned = uns;
        addr          = a;
        addr_next     = an;
        store_data    = sd;
        start         = 1'b1;
        tick();
        start         = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clk_enable = 1'b1; start = 1'b0; is_store = 1'b0;
        size = 2'b00; load_unsigned = 1'b0; addr = 32'h0; addr_next = 32'h0;
        store_data = 32'h0; mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset.busy got %b want 0", busy); else n_pass++;
        n_checks++; if (mif.mem_req !== 1'b0) $display("FAIL reset.mem_req got %b want 0", mif.mem_req); else n_pass++;
        n_checks++; if (mif.mem_wstrb !== 4'h0) $display("FAIL reset.mem_wstrb got %b want 0000", mif.mem_wstrb); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset.done got %b want 0", done); else n_pass++;
        n_checks++; if (load_data !== 32'h0) $display("FAIL reset.load_data got %h want 00000000", load_data); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_load();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEADBEEF;
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h104, 32'h0);
        n_checks++; if (mif.mem_req !== 1'b1) $display("FAIL word_load.req got %b want 1", mif.mem_req); else n_pass++;
        n_checks++; if (mif.mem_addr !== 32'h100) $display("FAIL word_load.addr got %h want 00000100", mif.mem_addr); else n_pass++;
        n_checks++; if ({mif.mem_we, mif.mem_wstrb} !== 5'b0) $display("FAIL word_load.we_strb got %b want 00000", {mif.mem_we, mif.mem_wstrb}); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL word_load.early_done got %b want 0", done); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL word_load.done got %b want 1", done); else n_pass++;
        n_checks++; if (load_data !== 32'hDEADBEEF) $display("FAIL word_load.data got %h want deadbeef", load_data); else n_pass++;
        n_checks++; if (mif.mem_req !== 1'b0) $display("FAIL word_load.req_in_done got %b want 0", mif.mem_req); else n_pass++;
        tick();
        n_checks++; if ({done, busy} !== 2'b00) $display("FAIL word_load.idle got %b want 00", {done, busy}); else n_pass++;
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_split_load(input logic uns, input logic [31:0] exp);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hAB000000;
        issue(1'b0, 2'b01, uns, 32'h103, 32'h107, 32'h0);
        n_checks++; if (mif.mem_addr !== 32'h100) $display("FAIL split_load.beat0_addr got %h want 00000100", mif.mem_addr); else n_pass++;
        tick();
        mif.mem_rdata = 32'h000000CD;
        n_checks++; if ({mif.mem_req, mif.mem_addr} !== {1'b1, 32'h104}) $display("FAIL split_load.beat1 got %b/%h want 1/00000104", mif.mem_req, mif.mem_addr); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL split_load.early_done got %b want 0", done); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL split_load.done got %b want 1", done); else n_pass++;
        n_checks++; if (load_data !== exp) $display("FAIL split_load.data uns=%b got %h want %h", uns, load_data, exp); else n_pass++;
        tick();
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_split_store();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFFFFFF;
        issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h106, 32'h11223344);
        n_checks++; if ({mif.mem_we, mif.mem_addr} !== {1'b1, 32'h100}) $display("FAIL split_store.beat0_addr got %b/%h want 1/00000100", mif.mem_we, mif.mem_addr); else n_pass++;
        n_checks++; if (mif.mem_wstrb !== 4'b1100) $display("FAIL split_store.beat0_strb got %b want 1100", mif.mem_wstrb); else n_pass++;
        n_checks++; if (mif.mem_wdata !== 32'h33440000) $display("FAIL split_store.beat0_data got %h want 33440000", mif.mem_wdata); else n_pass++;
        tick();
        n_checks++; if (mif.mem_addr !== 32'h104) $display("FAIL split_store.beat1_addr got %h want 00000104", mif.mem_addr); else n_pass++;
        n_checks++; if (mif.mem_wstrb !== 4'b0011) $display("FAIL split_store.beat1_strb got %b want 0011", mif.mem_wstrb); else n_pass++;
        n_checks++; if (mif.mem_wdata !== 32'h00001122) $display("FAIL split_store.beat1_data got %h want 00001122", mif.mem_wdata); else n_pass++;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL split_store.done got %b want 1", done); else n_pass++;
        n_checks++; if (load_data !== 32'h0000CDAB) $display("FAIL split_store.load_data_kept got %h want 0000cdab", load_data); else n_pass++;
        tick();
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_byte_load(input logic uns, input logic [31:0] exp);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000F000;
        issue(1'b0, 2'b00, uns, 32'h101, 32'h105, 32'h0);
        n_checks++; if (mif.mem_addr !== 32'h100) $display("FAIL byte_load.addr got %h want 00000100", mif.mem_addr); else n_pass++;
        tick();
        n_checks++; if ({done, mif.mem_req} !== 2'b10) $display("FAIL byte_load.single_beat got %b want 10", {done, mif.mem_req}); else n_pass++;
        n_checks++; if (load_data !== exp) $display("FAIL byte_load.data uns=%b got %h want %h", uns, load_data, exp); else n_pass++;
        tick();
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_stall_wait();
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h12345678;
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h204, 32'h0);
        clk_enable = 1'b0; mif.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({mif.mem_req, done, mif.mem_addr} !== {2'b10, 32'h200}) $display("FAIL stall.hold%0d got %b%b/%h want 10/00000200", i, mif.mem_req, done, mif.mem_addr); else n_pass++;
        end
        clk_enable = 1'b1; mif.mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if ({mif.mem_req, done, mif.mem_addr} !== {2'b10, 32'h200}) $display("FAIL wait.hold%0d got %b%b/%h want 10/00000200", i, mif.mem_req, done, mif.mem_addr); else n_pass++;
        end
        mif.mem_ack = 1'b1;
        tick();
        n_checks++; if (done !== 1'b1) $display("FAIL stall.done got %b want 1", done); else n_pass++;
        n_checks++; if (load_data !== 32'h12345678) $display("FAIL stall.data got %h want 12345678", load_data); else n_pass++;
        tick();
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_wrap();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBBAA0000;
        issue(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h00000002, 32'h0);
        n_checks++; if (mif.mem_addr !== 32'hFFFFFFFC) $display("FAIL wrap.beat0_addr got %h want fffffffc", mif.mem_addr); else n_pass++;
        tick();
        mif.mem_rdata = 32'h0000DDCC;
        n_checks++; if ({mif.mem_req, mif.mem_addr} !== {1'b1, 32'h0}) $display("FAIL wrap.beat1_addr got %b/%h want 1/00000000", mif.mem_req, mif.mem_addr); else n_pass++;
        tick();
        n_checks++; if (load_data !== 32'hDDCCBBAA) $display("FAIL wrap.data got %h want ddccbbaa", load_data); else n_pass++;
        tick();
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_start_in_done();
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h00000001;
        issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h404, 32'h0);
        tick();
        start = 1'b1;
        tick();
        n_checks++; if ({busy, mif.mem_req} !== 2'b00) $display("FAIL start_in_done.ignored got %b want 00", {busy, mif.mem_req}); else n_pass++;
        start = 1'b0;
        tick();
        mif.mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        mif.mem_ack = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 32'h102, 32'h106, 32'h11223344);
        tick();
        mif.mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({mif.mem_req, busy} !== 2'b00) $display("FAIL rst_mid.async got %b want 00", {mif.mem_req, busy}); else n_pass++;
        n_checks++; if ({mif.mem_we, mif.mem_wstrb} !== 5'b0) $display("FAIL rst_mid.we_strb got %b want 00000", {mif.mem_we, mif.mem_wstrb}); else n_pass++;
        n_checks++; if (load_data !== 32'h0) $display("FAIL rst_mid.load_data got %h want 00000000", load_data); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if ({done, busy} !== 2'b00) $display("FAIL rst_mid.no_resume got %b want 00", {done, busy}); else n_pass++;
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFEF00D;
        issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h304, 32'h0);
        n_checks++; if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {2'b10, 32'h300}) $display("FAIL rst_mid.clean_beat got %b%b/%h want 10/00000300", mif.mem_req, mif.mem_we, mif.mem_addr); else n_pass++;
        tick();
        n_checks++; if ({done, load_data} !== {1'b1, 32'hCAFEF00D}) $display("FAIL rst_mid.clean_done got %b/%h want 1/cafef00d", done, load_data); else n_pass++;
        tick();
        mif.mem_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_split_load(1'b0, 32'hFFFFCDAB);
        test_split_load(1'b1, 32'h0000CDAB);
        test_split_store();
        test_byte_load(1'b0, 32'hFFFFFFF0);
        test_byte_load(1'b1, 32'h000000F0);
        test_stall_wait();
        test_wrap();
        test_start_in_done();
        test_reset_mid_store();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, as listed below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 clk_enable  in  1  global stall; when low, all state and outputs hold.
REQ-005 start  in  1  request strobe; sampled only in IDLE with clk_enable=1.
REQ-006 is_store  in  1  1=store, 0=load; latched at start.
REQ-007 size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word; latched.
REQ-008 load_unsigned  in  1  1=zero-extend load result, 0=sign-extend; latched.
REQ-009 addr  in  32  byte address from ALU out; latched.
REQ-010 addr_next  in  32  ALU offset address (addr+4) used for the second beat; latched.
REQ-011 store_data  in  32  store value, right-justified; latched.
REQ-012 mem_req  out  1  memory beat request.
REQ-013 mem_we  out  1  beat is a write.
REQ-014 mem_addr  out  32  word-aligned beat address (bits [1:0]=0).
REQ-015 mem_wdata  out  32  lane-aligned write data.
REQ-016 mem_wstrb  out  4  byte-lane write strobes; 0000 on loads.
REQ-017 mem_ack  in  1  beat complete; sampled only while mem_req=1 and clk_enable=1.
REQ-018 mem_rdata  in  32  read data, valid in the ack cycle.
REQ-019 load_data  out  32  extended load result.
REQ-020 done  out  1  one-cycle completion pulse.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, BEAT0, BEAT1 and DONE, with registered state; all transitions occur only on edges where clk_enable=1.
REQ-023 IDLE->BEAT0 on start; all request fields are latched on the same edge; start in any other state SHALL be ignored.
REQ-024 nbytes = 1/2/4 per size; split = (addr[1:0] + nbytes > 4).
REQ-025 BEAT0: mem_req=1, mem_addr={addr[31:2],00}; on mem_ack go to BEAT1 if split, otherwise DONE.
REQ-026 BEAT1: mem_req=1, mem_addr={addr_next[31:2],00}; on mem_ack go to DONE.
REQ-027 DONE: done=1 for exactly one enabled cycle, then IDLE; a start in DONE SHALL be ignored.
REQ-028 mem_req, mem_we, mem_addr, mem_wdata and mem_wstrb SHALL be decoded from state and latched fields, and SHALL stay stable until ack.
REQ-029 Store lanes: form the 64-bit value store_data << 8*addr[1:0] and the 8-bit strobe mask ((1<<nbytes)-1) << addr[1:0]. BEAT0 uses the low 32 bits and low 4 strobes; BEAT1 uses the high halves. Unused lanes SHALL be driven to 0.
REQ-030 Load assembly: capture mem_rdata into a 64-bit buffer (low half at BEAT0 ack, high half at BEAT1 ack). Shift right by 8*addr[1:0], take nbytes, then zero- or sign-extend per load_unsigned.
REQ-031 load_data SHALL be updated on entry to DONE and held until the next load completes; stores SHALL NOT change load_data.
REQ-032 Latency: an unsplit access with ack in the first request cycle gives start edge, then 1 cycle of mem_req, then done in the next cycle (3 cycles). A split access adds one cycle per beat plus any ack wait cycles.
REQ-033 When clk_enable=0, a mem_ack SHALL be ignored and the beat SHALL remain requested.
REQ-034 Address wrap: addr_next is used as supplied, so 0xFFFFFFFE+4 gives a BEAT1 address of 0x00000000, with no fault.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, clear latched fields, set load_data=0, and drive mem_req=0, mem_we=0, mem_wstrb=0000, done=0 and busy=0, including when reset arrives mid-beat; no beat is resumed after reset.

Verification
REQ-036 Aligned word load: addr 0x100, size 10, rdata 0xDEADBEEF, ack in the first cycle -> one beat at 0x100; load_data 0xDEADBEEF; done 3 cycles after start.
REQ-037 Split signed half load: addr 0x103, addr_next 0x107, rdata0 0xAB000000, rdata1 0x000000CD -> beats at 0x100 and 0x104; load_data 0xFFFFCDAB (0x0000CDAB when unsigned).
REQ-038 Split word store: addr 0x102, data 0x11223344 -> beat0 0x100 wstrb 1100 wdata 0x33440000; beat1 0x104 wstrb 0011 wdata 0x00001122.
REQ-039 Byte load: addr 0x101, rdata 0x0000F000 -> signed load_data 0xFFFFFFF0, unsigned load_data 0x000000F0; one beat only.
REQ-040 Stall and wait: hold clk_enable=0 for 3 cycles with mem_ack=1 during BEAT0, then delay ack by 2 enabled cycles -> mem_req and mem_addr are held stable, no early done, and the result is correct.
REQ-041 Reset mid-split-store: drop rst_n during BEAT1 -> mem_req and busy fall without waiting for a clock edge; no done; the next start runs a clean beat sequence.
